// File: rtl/incr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin incrementer arbiter.
// IDLE means no response is held; HOLD means rsp_* carries a valid result.
package incr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 70;

endpackage

// File: rtl/incr_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the response consumer.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface incr_arbiter_if
    import incr_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_carry;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
    );

endinterface

// File: rtl/incr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping modulo NREQ,
// and returns the first set bit as a one-hot grant plus its index.
module rr_pick
    import incr_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    // cand_idx[k] is the requester examined at search position k.
    logic [IW-1:0] cand_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IW:0] pos_sum;
            assign pos_sum      = {1'b0, ptr} + (IW+1)'(gi);
            assign cand_idx[gi] = (pos_sum >= (IW+1)'(NREQ)) ?
                                  IW'(pos_sum - (IW+1)'(NREQ)) : pos_sum[IW-1:0];
        end
    endgenerate

    // Scan from the far end so the nearest candidate to ptr is the last to win.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                grant              = '0;
                grant[cand_idx[k]] = 1'b1;
                idx                = cand_idx[k];
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/incr_arbiter.sv
// Round-robin arbiter sharing one WIDTH+1-bit incrementer among NREQ requesters,
// returning operand+1 with carry one cycle after grant and holding it under backpressure.
module incr_arbiter
    import incr_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    incr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    state_t           state_reg, state_next;
    logic [IW-1:0]    rr_ptr_reg;
    logic [IW-1:0]    rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_carry_reg;

    logic [NREQ-1:0]  pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             accept;
    logic             fire;

    logic [WIDTH-1:0] operand [NREQ];
    logic [WIDTH-1:0] sel_operand;
    logic [WIDTH:0]   inc_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_operand
            assign operand[gi] = bus.req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Only the granted operand reaches the single shared adder.
    assign sel_operand = operand[pick_idx];
    assign inc_sum     = {1'b0, sel_operand} + (WIDTH+1)'(1);

    always_comb begin
        state_next    = state_reg;
        accept        = 1'b0;
        fire          = 1'b0;
        bus.req_ready = '0;
        if (state_reg == IDLE || bus.rsp_ready) begin
            accept     = 1'b1;
            state_next = pick_any ? HOLD : IDLE;
        end
        fire = accept && pick_any;
        // Gated by reset so req_ready drops immediately while reset is held.
        if (accept && !reset) begin
            bus.req_ready = pick_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fire) begin
                rr_ptr_reg    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                rsp_id_reg    <= pick_idx;
                rsp_data_reg  <= inc_sum[WIDTH-1:0];
                rsp_carry_reg <= inc_sum[WIDTH];
            end
        end
    end

    assign bus.rsp_valid = (state_reg == HOLD);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_carry = rsp_carry_reg;

endmodule

// File: doc/incr_arbiter.md
INCR_ARBITER -- requirements
Module: incr_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the incrementer (2..8).
REQ-002 Parameter: WIDTH, 70, operand/result width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  NREQ  per-requester request valid.
REQ-006 Port: req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-007 Port: req_data  input  NREQ*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 Port: rsp_valid  output  1  response valid.
REQ-009 Port: rsp_ready  input  1  response consumer ready.
REQ-010 Port: rsp_id  output  $clog2(NREQ)  index of requester owning the response.
REQ-011 Port: rsp_data  output  WIDTH  operand + 1, modulo 2^WIDTH.
REQ-012 Port: rsp_carry  output  1  carry-out of the increment; set only when the operand was all-ones.

Function
REQ-013 The block SHALL have two states: IDLE (no response held) and HOLD (response held on rsp_*).
REQ-014 Acceptance SHALL be enabled when state is IDLE, or when state is HOLD and rsp_ready=1.
REQ-015 When acceptance is enabled and any req_valid is set, exactly one req_ready bit SHALL assert combinationally in that cycle, for the granted requester.
REQ-016 Grant SHALL be round-robin: search starts at rr_ptr and wraps modulo NREQ; the first set req_valid wins.
REQ-017 On a grant to requester g, rr_ptr SHALL update to (g+1) mod NREQ at the next edge; rr_ptr SHALL be unchanged when nothing is granted.
REQ-018 A grant in cycle N SHALL present rsp_valid=1, rsp_id=g, and rsp_data/rsp_carry = {carry, sum} of req_data[g]+1 in cycle N+1, giving a fixed latency of 1.
REQ-019 In HOLD with rsp_ready=0, rsp_valid, rsp_id, rsp_data and rsp_carry SHALL remain stable, and req_ready SHALL be all-zero.
REQ-020 In HOLD with rsp_ready=1 and no request, the state SHALL return to IDLE and rsp_valid SHALL deassert next cycle.
REQ-021 In HOLD with rsp_ready=1 and a request, the new grant SHALL replace the response next cycle with no bubble, giving 1 result per cycle sustained.
REQ-022 rsp_ready SHALL be ignored in IDLE.
REQ-023 Increment SHALL wrap: an all-ones operand SHALL yield rsp_data=0 and rsp_carry=1.
REQ-024 req_data of ungranted requesters SHALL have no effect.
REQ-025 req_ready SHALL NOT depend on req_data.

Reset
REQ-026 While reset=1, the block SHALL force state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0 and req_ready=0, asynchronously.
REQ-027 Reset asserted while in HOLD SHALL discard the held response with no later replay.
REQ-028 The first grant after reset deassertion SHALL favour requester 0 when several are valid.

Structure
REQ-029 A shared package incr_arbiter_pkg SHALL hold the state enum (IDLE, HOLD) and the default NREQ/WIDTH constants.
REQ-030 Round-robin selection SHALL live in sub-module rr_pick, a combinational block with inputs req vector and ptr, and outputs one-hot grant, index and any flag.
REQ-031 The incrementer SHALL be a single shared WIDTH+1-bit adder instance feeding the response register.

Verification
REQ-032 Single request: reset, then req_valid=0001, operand 5, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=6, rsp_carry=0.
REQ-033 Wrap: operand 70'h3F_FFFF_FFFF_FFFF_FFFF on requester 2 -> rsp_data=0, rsp_carry=1, rsp_id=2.
REQ-034 Fairness: req_valid=1111 held for 8 cycles, rsp_ready=1 -> grants 0,1,2,3,0,1,2,3, one response per cycle, no bubbles.
REQ-035 Backpressure: request on requester 1 with operand 9, rsp_ready=0 for 3 cycles -> rsp_data=10 stable and req_ready=0 throughout; when rsp_ready=1 is raised with a request on requester 3 pending, requester 3's result appears next cycle.
REQ-036 Reset mid-HOLD: reset pulsed while rsp_valid=1 -> all outputs 0 immediately; after release no stale response appears, and req_valid=1010 grants requester 1 first.
